// File: rtl/mem_access_ctrl.sv
// Request sequencer for the 2048x16 synchronous memory.
// Turns one CPU valid/ready request into a single-cycle rd or wr strobe.
module mem_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    WR_ISSUE
  } state_t;

  state_t            state_q, state_d;
  logic              ack_d, rd_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d, rdata_d;

  assign ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = mem_address;
    din_d   = mem_data_in;
    rdata_d = rdata;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = req_addr;
          din_d  = req_wdata;
          if (req_we) begin
            wr_d    = 1'b1;
            state_d = WR_ISSUE;
          end else begin
            rd_d    = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      // memory registers its output on this edge
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = mem_data_out;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      WR_ISSUE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack         <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rdata       <= '0;
    end else begin
      state_q     <= state_d;
      ack         <= ack_d;
      mem_rd      <= rd_d;
      mem_wr      <= wr_d;
      mem_address <= addr_d;
      mem_data_in <= din_d;
      rdata       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural
// 2048x16 registered-read memory attached.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        req_we;
  logic [10:0] req_addr;
  logic [15:0] req_wdata;
  logic        ready;
  logic        ack;
  logic [15:0] rdata;
  logic [10:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_data_out;

  logic [15:0] mem [0:2047];

  int pass_cnt = 0;
  int total    = 0;
  int ack_cnt  = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int ovl_cnt  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ready        (ready),
    .ack          (ack),
    .rdata        (rdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out)
  );

  always @(posedge clk) begin
    if (mem_wr === 1'b1) mem[mem_address] <= mem_data_in;
    if (mem_rd === 1'b1) mem_data_out <= mem[mem_address];
  end

  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
    if (mem_rd === 1'b1) rd_cnt++;
    if (mem_wr === 1'b1) wr_cnt++;
    if (mem_rd === 1'b1 && mem_wr === 1'b1) ovl_cnt++;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ack, mem_rd, mem_wr} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000", {ack, mem_rd, mem_wr});
    else pass_cnt++;
    total++;
    if (mem_address !== 11'd0 || mem_data_in !== 16'd0)
      $display("FAIL reset_addr got %h/%h want 0/0", mem_address, mem_data_in);
    else pass_cnt++;
    total++;
    if (rdata !== 16'd0 || ready !== 1'b1)
      $display("FAIL reset_rdata_ready got %h/%b want 0/1", rdata, ready);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    int r0;
    r0 = rd_cnt;
    req = 1'b1; req_we = 1'b0; req_addr = 11'd10; req_wdata = 16'h0;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (mem_rd !== 1'b1 || ready !== 1'b0)
      $display("FAIL rd_issue rd/ready got %b/%b want 1/0", mem_rd, ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({mem_rd, ready, ack} !== 3'b000)
      $display("FAIL rd_cap rd/ready/ack got %b want 000", {mem_rd, ready, ack});
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (ack !== 1'b1 || rdata !== 16'h0009 || ready !== 1'b1)
      $display("FAIL rd_ack ack/rdata/ready got %b/%h/%b want 1/0009/1",
               ack, rdata, ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || rd_cnt - r0 != 1)
      $display("FAIL rd_once ack/rd_cycles got %b/%0d want 0/1", ack, rd_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    req = 1'b1; req_we = 1'b1; req_addr = 11'd12; req_wdata = 16'h0005;
    @(negedge clk);
    total++;
    if (mem_wr !== 1'b1 || ready !== 1'b0)
      $display("FAIL b2b_wr_issue wr/ready got %b/%b want 1/0", mem_wr, ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (ack !== 1'b1 || mem_wr !== 1'b0 || ready !== 1'b1)
      $display("FAIL b2b_wr_ack ack/wr/ready got %b/%b/%b want 1/0/1",
               ack, mem_wr, ready);
    else pass_cnt++;
    req_we = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || mem_rd !== 1'b1)
      $display("FAIL b2b_rd_accept ack/rd got %b/%b want 0/1", ack, mem_rd);
    else pass_cnt++;
    req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ack !== 1'b1 || rdata !== 16'h0005)
      $display("FAIL b2b_rd_ack ack/rdata got %b/%h want 1/0005", ack, rdata);
    else pass_cnt++;
    total++;
    if (ovl_cnt != 0)
      $display("FAIL b2b_overlap got %0d want 0", ovl_cnt);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    int a0, w0;
    a0 = ack_cnt; w0 = wr_cnt;
    req = 1'b1; req_we = 1'b0; req_addr = 11'd11; req_wdata = 16'h0;
    @(negedge clk);
    req_addr = 11'd10; req_we = 1'b1; req_wdata = 16'h1234;
    @(negedge clk);
    total++;
    if (mem_address !== 11'd11 || mem_data_in !== 16'h0000)
      $display("FAIL busy_latched addr/din got %h/%h want 00b/0000",
               mem_address, mem_data_in);
    else pass_cnt++;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (ack !== 1'b1 || rdata !== 16'hFFFC)
      $display("FAIL busy_rd_ack ack/rdata got %b/%h want 1/fffc", ack, rdata);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total++;
    if (ack_cnt - a0 != 1 || wr_cnt != w0 || mem[10] !== 16'h0009)
      $display("FAIL busy_single acks/wr/mem10 got %0d/%0d/%h want 1/0/0009",
               ack_cnt - a0, wr_cnt - w0, mem[10]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int a0;
    a0 = ack_cnt;
    req = 1'b1; req_we = 1'b0; req_addr = 11'd10;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({ack, mem_rd, ready} !== 3'b001 || rdata !== 16'h0)
      $display("FAIL rstmid ack/rd/ready/rdata got %b/%h want 001/0000",
               {ack, mem_rd, ready}, rdata);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ack_cnt != a0)
      $display("FAIL rstmid_no_ack got %0d acks want 0", ack_cnt - a0);
    else pass_cnt++;
  endtask

  task automatic test_stream;
    logic        we_t [4];
    logic [10:0] ad_t [4];
    logic [15:0] wd_t [4];
    int a0, cyc;
    we_t = '{1'b1, 1'b0, 1'b1, 1'b0};
    ad_t = '{11'h7FF, 11'h7FF, 11'h000, 11'h000};
    wd_t = '{16'hA5A5, 16'h0, 16'h5A5A, 16'h0};
    a0 = ack_cnt;
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_we = we_t[i]; req_addr = ad_t[i]; req_wdata = wd_t[i];
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ack !== 1'b1 && cyc < 10);
      total++;
      if (cyc != (we_t[i] ? 2 : 3))
        $display("FAIL stream_lat[%0d] got %0d cycles want %0d",
                 i, cyc, we_t[i] ? 2 : 3);
      else pass_cnt++;
      if (!we_t[i]) begin
        total++;
        if (rdata !== wd_t[i-1])
          $display("FAIL stream_rdata[%0d] got %h want %h", i, rdata, wd_t[i-1]);
        else pass_cnt++;
      end
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ack_cnt - a0 != 4 || ovl_cnt != 0)
      $display("FAIL stream_acks acks/overlap got %0d/%0d want 4/0",
               ack_cnt - a0, ovl_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_hold;
    int bad;
    bad = 0;
    rst_n = 1'b0;
    req = 1'b1; req_we = 1'b1; req_addr = 11'd5; req_wdata = 16'h0007;
    repeat (3) begin
      @(negedge clk);
      if ({mem_rd, mem_wr, ack} !== 3'b000) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL rsthold_quiet got %0d busy cycles want 0", bad);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (mem_wr !== 1'b1 || mem_address !== 11'd5)
      $display("FAIL rsthold_accept wr/addr got %b/%h want 1/005",
               mem_wr, mem_address);
    else pass_cnt++;
    req = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b1)
      $display("FAIL rsthold_ack got %b want 1", ack);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (mem[5] !== 16'h0007)
      $display("FAIL rsthold_mem5 got %h want 0007", mem[5]);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    mem[10] = 16'h0009;
    mem[11] = 16'hFFFC;
    mem_data_out = 16'h0;
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0;
    req_addr = 11'd0; req_wdata = 16'd0;
    @(negedge clk);
    test_reset;
    test_read;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid;
    test_stream;
    test_reset_hold;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d/%0d checks", pass_cnt, total);
    $fatal(1);
  end

endmodule
